expr_buffer: RTL
================

Name: expr_buffer

Overview:
- Receiving end of the keypad interface: consumes the level-held dataIn/insert/del/ptrLeft/ptrRight/eval signals.
- Edge-detects each control so one press produces exactly one action.
- Maintains an editable token buffer with a cursor.
- On eval, streams the stored expression to the evaluator over a valid/ready handshake.

Parameters:
- width, 8, token width in bits.
- depth, 16, maximum tokens stored; derived PW = $clog2(depth+1) for cursor/size fields.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- dataIn  input  width  token code; sampled on the insert rising edge.
- insert  input  1  level; rising edge = insert token.
- del  input  1  level; rising edge = backspace.
- ptrLeft  input  1  level; rising edge = cursor left.
- ptrRight  input  1  level; rising edge = cursor right.
- eval  input  1  level; rising edge = start stream.
- size  output  PW  tokens stored.
- ptr  output  PW  cursor, 0..size; insertion point.
- full  output  1  size==depth.
- empty  output  1  size==0.
- busy  output  1  stream in progress.
- out_data  output  width  streamed token.
- out_valid  output  1  out_data valid.
- out_last  output  1  marks final token of the stream.
- out_ready  input  1  downstream accepts.
- done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (async, active-high):
  - all buffer entries, size, ptr, busy, out_data, out_valid, out_last, done are 0;
  - edge-detect history regs are 0;
  - empty=1, full=0.
- Edge detect: per control, rise = in & ~prev; prev <= in every cycle, including while busy.
  - A signal held high from reset release counts as one rise.
- Action selection: at most one action per cycle. Priority: eval > insert > del > ptrLeft > ptrRight. Lower-priority rises in the same cycle are discarded, not queued.
- Edit commit: takes effect at the same clock edge that samples the rise. size/ptr/buffer are visible the following cycle (1-cycle latency).
- insert:
  - if !full: buf[ptr..size-1] shift up one slot; buf[ptr] <= dataIn; ptr+1; size+1.
  - if full: no change.
- del:
  - if ptr>0: buf[ptr-1] removed; entries above shift down; ptr-1; size-1; vacated top slot <= 0.
  - if ptr==0: no change, including when size>0.
- ptrLeft: ptr-1 if ptr>0, else no change.
- ptrRight: ptr+1 if ptr<size, else no change.
- Shifts are single-cycle across the whole register array; no multi-cycle move state.
- Stream FSM, states IDLE, SEND, DONE:
  - IDLE, eval rise and size>0: -> SEND; idx=0; busy=1; out_valid=1; out_data=buf[0]; out_last=(size==1).
  - IDLE, eval rise and size==0: ignored, stay IDLE.
  - SEND: out_data/out_last held stable while out_valid & !out_ready.
  - SEND, handshake with !out_last: idx+1; out_data=buf[idx+1]; out_last=(idx+1==size-1).
  - SEND, handshake with out_last: out_valid=0 -> DONE.
  - DONE: done=1 for one cycle; busy=0; -> IDLE.
- While busy: all edit and eval rises are discarded; the buffer is frozen. History regs still update, so a key held through the stream does not fire afterwards.
- Reset mid-stream: immediate return to IDLE with outputs cleared.
- ptr/size never exceed depth. Widths are PW; no wrap-around.

Optional Feature:
- CLEAR_ON_EVAL_EN defined: in the DONE state, size, ptr and all entries clear to 0 in the same cycle done pulses, ready for a new expression.
- CLEAR_ON_EVAL_EN undefined: buffer and cursor are retained after the stream for further editing.

Test Plan:
- Insert sequence:
  - stimulus: insert pulses with dataIn 0x01, 0xA0, 0x02 (each held 3 cycles);
  - response: size=3, ptr=3, buf=[01,A0,02]; holding insert 10 cycles adds one token only.
- Mid-cursor edit:
  - stimulus: from [01,A0,02] ptr=3, apply ptrLeft x2, insert 0xA4, then del;
  - response: after insert, buf=[01,A4,A0,02] ptr=2; after del, buf=[01,A0,02] ptr=1.
- Boundaries:
  - stimulus: del at ptr=0; ptrLeft at ptr=0; ptrRight at ptr==size; insert when 16 tokens stored;
  - response: no change in each case; full=1 stays with size=16.
- Simultaneous rises:
  - stimulus: insert and del rise in the same cycle;
  - response: only insert applied; del is lost.
  - stimulus: eval and insert rise together with size=2;
  - response: stream starts, no insert.
- Stream with backpressure:
  - stimulus: buf=[05,A2,03]; eval; out_ready low for cycles 0-2, then high;
  - response: out_data=05 held stable until accepted, then A2, then 03 with out_last=1; done pulses one cycle later; busy=0.
  - Edits during busy are ignored.
  - With CLEAR_ON_EVAL_EN: size=0 after done. Without it: size stays 3.
- Reset: assert reset mid-SEND -> out_valid=0, busy=0, size=0, ptr=0 immediately (asynchronous).

Source files
------------

// File: rtl/expr_buffer_if.sv
// Keypad-side controls, buffer status and evaluator stream bundled for expr_buffer.
// master = keypad/evaluator environment, slave = expr_buffer.
interface expr_buffer_if #(
    parameter int width = 8,
    parameter int depth = 16
);
    localparam int PW = $clog2(depth + 1);

    logic [width-1:0] dataIn;
    logic             insert;
    logic             del;
    logic             ptrLeft;
    logic             ptrRight;
    logic             eval;
    logic [PW-1:0]    size;
    logic [PW-1:0]    ptr;
    logic             full;
    logic             empty;
    logic             busy;
    logic [width-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output dataIn, insert, del, ptrLeft, ptrRight, eval, out_ready,
        input  size, ptr, full, empty, busy, out_data, out_valid, out_last, done, state_dbg
    );

    modport slave (
        input  dataIn, insert, del, ptrLeft, ptrRight, eval, out_ready,
        output size, ptr, full, empty, busy, out_data, out_valid, out_last, done, state_dbg
    );
endinterface

// File: rtl/expr_buffer.sv
// Editable token buffer with cursor, fed by edge-detected keypad levels; streams on eval.
// Optional macro CLEAR_ON_EVAL_EN: wipe buffer and cursor in the DONE cycle.
module expr_buffer #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic         clock,
    input  logic         reset,
    expr_buffer_if.slave bus
);
    localparam int PW = $clog2(depth + 1);
    localparam int IW = (depth > 1) ? $clog2(depth) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [width-1:0] tok_q [depth];
    logic [width-1:0] tok_d [depth];
    logic [PW-1:0]    size_q, size_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [4:0]       prev_q;
    logic [4:0]       keys;
    logic [4:0]       rise;
    logic             last;

    // Order sets priority: eval > insert > del > ptrLeft > ptrRight.
    assign keys = {bus.eval, bus.insert, bus.del, bus.ptrLeft, bus.ptrRight};
    assign rise = keys & ~prev_q;
    assign last = (PW'(idx_q) == size_q - 1'b1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        size_d  = size_q;
        ptr_d   = ptr_q;
        tok_d   = tok_q;
        unique case (state_q)
            IDLE: begin
                if (rise[4]) begin
                    if (size_q != '0) begin
                        state_d = SEND;
                        idx_d   = '0;
                    end
                end else if (rise[3]) begin
                    if (size_q != PW'(depth)) begin
                        for (int i = 1; i < depth; i++)
                            if (PW'(i) > ptr_q && PW'(i) <= size_q) tok_d[i] = tok_q[i-1];
                        for (int i = 0; i < depth; i++)
                            if (PW'(i) == ptr_q) tok_d[i] = bus.dataIn;
                        ptr_d  = ptr_q + 1'b1;
                        size_d = size_q + 1'b1;
                    end
                end else if (rise[2]) begin
                    if (ptr_q != '0) begin
                        for (int i = 0; i < depth - 1; i++)
                            if (PW'(i) >= ptr_q - 1'b1 && PW'(i) < size_q - 1'b1) tok_d[i] = tok_q[i+1];
                        for (int i = 0; i < depth; i++)
                            if (PW'(i) == size_q - 1'b1) tok_d[i] = '0;
                        ptr_d  = ptr_q - 1'b1;
                        size_d = size_q - 1'b1;
                    end
                end else if (rise[1]) begin
                    if (ptr_q != '0) ptr_d = ptr_q - 1'b1;
                end else if (rise[0]) begin
                    if (ptr_q < size_q) ptr_d = ptr_q + 1'b1;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (last) state_d = DONE;
                    else      idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef CLEAR_ON_EVAL_EN
                size_d = '0;
                ptr_d  = '0;
                for (int i = 0; i < depth; i++) tok_d[i] = '0;
`else
                size_d = size_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            size_q  <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            prev_q  <= '0;
            for (int i = 0; i < depth; i++) tok_q[i] <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            prev_q  <= keys;
            for (int i = 0; i < depth; i++) tok_q[i] <= tok_d[i];
        end
    end

    // Stream handshake: a token transfers on a rising edge where out_valid and out_ready
    // are both high; while out_valid is high and out_ready low, out_data/out_last hold.
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = (state_q == SEND) ? tok_q[idx_q] : '0;
    assign bus.out_last  = (state_q == SEND) && last;
    assign bus.busy      = (state_q == SEND);
    assign bus.done      = (state_q == DONE);
    assign bus.size      = size_q;
    assign bus.ptr       = ptr_q;
    assign bus.full      = (size_q == PW'(depth));
    assign bus.empty     = (size_q == '0);
    assign bus.state_dbg = state_q;
endmodule
